// File: rtl/vec_add_pkg.sv
// vec_add_pkg
// Shared types and constants for the vector-add result path.
// Holds the cache-line geometry, the result word type and the
// write-back FSM state encoding used by vec_result_writer.
package vec_add_pkg;

  localparam int WORDS_PER_LINE = 16;
  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = 512;
  localparam int ADDR_BITS      = 42;
  localparam int RD_ADDR_BITS   = 6;

  typedef logic [WORD_BITS-1:0] t_result_word;
  typedef logic [LINE_BITS-1:0] t_line;
  typedef logic [ADDR_BITS-1:0] t_line_addr;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    SEND     = 3'd2,
    WAIT_RSP = 3'd3,
    FIN      = 3'd4
  } t_wr_state;

endpackage

// File: rtl/vec_result_writer_if.sv
// vec_result_writer_if
// Bundles the control, result-buffer and host write-channel signals of
// vec_result_writer.
//   master : the writer (drives z_rd_addr, wr_*, busy, done)
//   slave  : the surrounding AFU / result buffer / host channel
interface vec_result_writer_if;
  import vec_add_pkg::*;

  logic                    start;
  t_line_addr              base_addr;
  logic [RD_ADDR_BITS-1:0] z_rd_addr;
  t_result_word            z_dout;
  logic                    wr_alm_full;
  logic                    wr_valid;
  t_line_addr              wr_addr;
  t_line                   wr_data;
  logic                    wr_rsp_valid;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, base_addr, z_dout, wr_alm_full, wr_rsp_valid,
    output z_rd_addr, wr_valid, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, base_addr, z_dout, wr_alm_full, wr_rsp_valid,
    input  z_rd_addr, wr_valid, wr_addr, wr_data, busy, done
  );

endinterface

// File: rtl/vec_line_packer.sv
// vec_line_packer
// Assembles one 512-bit cache line from 32-bit result words.
// Word i lands in bits [32i+31:32i].
//   clk        : sole clock
//   word_idx   : slot to write
//   word       : result word to insert
//   wr_en      : insert word at word_idx this cycle
//   clear      : zero the whole line (takes priority over wr_en)
//   packed_line: current line contents
module vec_line_packer
  import vec_add_pkg::*;
#(
  parameter int WORDS_PER_LINE = vec_add_pkg::WORDS_PER_LINE
) (
  input  logic                              clk,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
  input  t_result_word                      word,
  input  logic                              wr_en,
  input  logic                              clear,
  output t_line                             packed_line
);

  always_ff @(posedge clk) begin
    if (clear) begin
      packed_line <= '0;
    end else if (wr_en) begin
      packed_line[word_idx*WORD_BITS +: WORD_BITS] <= word;
    end
  end

endmodule

// File: rtl/vec_result_writer.sv
// vec_result_writer
// Drains NUM_WORDS result words from the result buffer, packs them into
// 512-bit lines and issues one host write per line, then waits until all
// write responses are back before pulsing done.
//   clk, reset : sole clock, synchronous active-high reset
//   bus.start        : one-cycle pulse, accepted only while idle
//   bus.base_addr    : line address of line 0, latched on accepted start
//   bus.z_rd_addr    : result-buffer read address
//   bus.z_dout       : result-buffer data, one cycle after z_rd_addr
//   bus.wr_alm_full  : host write channel almost full (stalls SEND)
//   bus.wr_valid     : one-cycle write-line request
//   bus.wr_addr      : line address of the request
//   bus.wr_data      : packed line of the request
//   bus.wr_rsp_valid : one write completion per high cycle
//   bus.busy         : high from accepted start until done
//   bus.done         : one-cycle pulse when everything is acknowledged
module vec_result_writer
  import vec_add_pkg::*;
#(
  parameter int NUM_WORDS      = 64,
  parameter int WORDS_PER_LINE = vec_add_pkg::WORDS_PER_LINE
) (
  input logic              clk,
  input logic              reset,
  vec_result_writer_if.master bus
);

  localparam int NUM_LINES = NUM_WORDS / WORDS_PER_LINE;
  localparam int IDX_BITS  = $clog2(WORDS_PER_LINE);
  localparam int FILL_BITS = $clog2(WORDS_PER_LINE + 1);

  localparam logic [FILL_BITS-1:0] LAST_FILL = FILL_BITS'(WORDS_PER_LINE);
  localparam logic [FILL_BITS-1:0] LAST_RD   = FILL_BITS'(WORDS_PER_LINE - 1);
  localparam logic [6:0]           LAST_LINE = 7'(NUM_LINES - 1);
  localparam logic [6:0]           ALL_RSP   = 7'(NUM_LINES);

  t_wr_state             state;
  t_line_addr            base_q;
  logic [6:0]            line_idx;
  logic [6:0]            rsp_cnt;
  logic [FILL_BITS-1:0]  fill_cnt;
  logic [IDX_BITS-1:0]   cap_idx;
  logic                  cap_en;
  logic                  accept;
  logic                  send_fire;
  t_line                 line;

  assign accept    = (state == IDLE) && bus.start;
  assign send_fire = (state == SEND) && !bus.wr_alm_full;

  // fill_cnt counts FILL cycles; the word read at count c-1 arrives at count c
  assign cap_en  = (state == FILL) && (fill_cnt != '0);
  assign cap_idx = IDX_BITS'(fill_cnt - 1'b1);

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FIN);

  vec_line_packer #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_packer (
    .clk         (clk),
    .word_idx    (cap_idx),
    .word        (bus.z_dout),
    .wr_en       (cap_en),
    .clear       (accept),
    .packed_line (line)
  );

  // Main FSM: read words, send the line, repeat, then collect responses
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_idx      <= '0;
      rsp_cnt       <= '0;
      fill_cnt      <= '0;
      bus.z_rd_addr <= '0;
      bus.wr_valid  <= 1'b0;
    end else begin
      bus.wr_valid <= 1'b0;

      // Responses may overtake the FSM, so count them in every busy state
      if ((state != IDLE) && bus.wr_rsp_valid) begin
        rsp_cnt <= rsp_cnt + 7'd1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            line_idx      <= '0;
            rsp_cnt       <= '0;
            fill_cnt      <= '0;
            bus.z_rd_addr <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt < LAST_RD) begin
            bus.z_rd_addr <= bus.z_rd_addr + 1'b1;
          end
          if (fill_cnt == LAST_FILL) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (!bus.wr_alm_full) begin
            bus.wr_valid <= 1'b1;
            line_idx     <= line_idx + 7'd1;
            if (line_idx == LAST_LINE) begin
              state <= WAIT_RSP;
            end else begin
              fill_cnt      <= '0;
              bus.z_rd_addr <= RD_ADDR_BITS'((32'(line_idx) + 1) * WORDS_PER_LINE);
              state         <= FILL;
            end
          end
        end
        WAIT_RSP: begin
          if (rsp_cnt == ALL_RSP) begin
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath registers with no reset: base latch and write request payload
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= bus.base_addr;
    end
    if (send_fire) begin
      bus.wr_addr <= base_q + ADDR_BITS'(line_idx);
      bus.wr_data <= line;
    end
  end

endmodule

// File: tb/tb_vec_result_writer.sv
// tb_vec_result_writer
// Directed self-checking bench for vec_result_writer: reset state, plain
// drains with timing, host back-pressure, address wrap, mid-drain reset,
// and ignored start / stray response pulses.
module tb_vec_result_writer;
  import vec_add_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vec_result_writer_if bus ();

  vec_result_writer #(
    .NUM_WORDS      (64),
    .WORDS_PER_LINE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_cyc    = 0;

  // Result buffer model: one-cycle read latency
  logic [31:0] zmem [0:63];
  always @(posedge clk) bus.z_dout <= zmem[bus.z_rd_addr];

  // Host responder: one completion 5 cycles after each write request
  logic [4:0] rsp_pipe = '0;
  logic       rsp_en = 1'b1;
  logic       rsp_manual = 1'b0;
  always @(posedge clk) rsp_pipe <= {rsp_pipe[3:0], bus.wr_valid};
  assign bus.wr_rsp_valid = (rsp_en && rsp_pipe[4]) || rsp_manual;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done log sampled mid-cycle
  logic [41:0]  wa_q [$];
  logic [511:0] wd_q [$];
  int           wc_q [$];
  int           done_cnt = 0;
  int           done_cyc = 0;
  logic         done_prev = 1'b0;
  logic         busy_after_done = 1'b1;

  always @(negedge clk) begin
    if (bus.wr_valid) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
    end
    if (done_prev) busy_after_done = bus.busy;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    done_prev = bus.done;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] zval(input int pat, input int i);
    case (pat)
      0:       zval = 32'(i);
      1:       zval = 32'hC0DE_0000 + 32'(i * 3);
      default: zval = ~32'(i) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [511:0] exp_line(input int pat, input int ln);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = zval(pat, ln * 16 + k);
    return l;
  endfunction

  task automatic load_mem(input int pat);
    for (int i = 0; i < 64; i++) zmem[i] = zval(pat, i);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_cnt = 0;
    busy_after_done = 1'b1;
  endtask

  function automatic int get_cyc(input int i);
    return (i < wc_q.size()) ? wc_q[i] - start_cyc : -1;
  endfunction

  function automatic logic [511:0] get_data(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 'x;
  endfunction

  function automatic logic [41:0] get_addr(input int i);
    return (i < wa_q.size()) ? wa_q[i] : 'x;
  endfunction

  task automatic apply_start(input logic [41:0] base);
    @(negedge clk);
    bus.base_addr = base;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic pulse_start_raw(input logic [41:0] base);
    @(negedge clk);
    bus.base_addr = base;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int rel);
    while (cyc < start_cyc + rel) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check_output({tag, "_done_seen"}, 512'(ok), 512'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_drain(input string tag, input int pat, input logic [41:0] base);
    logic [41:0] ea;
    check_output({tag, "_nwrites"}, 512'(wa_q.size()), 512'd4);
    for (int i = 0; i < 4; i++) begin
      ea = base + 42'(i);
      check_output($sformatf("%s_addr%0d", tag, i), 512'(get_addr(i)), 512'(ea));
      check_output($sformatf("%s_data%0d", tag, i), get_data(i), exp_line(pat, i));
    end
    check_output({tag, "_done_cnt"}, 512'(done_cnt), 512'd1);
    check_output({tag, "_busy_after_done"}, 512'(busy_after_done), 512'd0);
  endtask

  initial begin
    logic [511:0] l;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.wr_alm_full = 1'b0;
    load_mem(0);

    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_wr_valid", 512'(bus.wr_valid), 512'd0);
    check_output("rst_done", 512'(bus.done), 512'd0);
    check_output("rst_busy", 512'(bus.busy), 512'd0);
    check_output("rst_z_rd_addr", 512'(bus.z_rd_addr), 512'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("post_rst_busy", 512'(bus.busy), 512'd0);

    // Plain drain, z[i]=i, base 0x1000
    clear_log();
    apply_start(42'h1000);
    check_output("t2_busy_after_start", 512'(bus.busy), 512'd1);
    wait_done("t2", 200);
    check_drain("t2", 0, 42'h1000);
    l = get_data(0);
    check_output("t2_l0_w0", 512'(l[31:0]), 512'd0);
    check_output("t2_l0_w15", 512'(l[511:480]), 512'd15);
    l = get_data(3);
    check_output("t2_l3_w15", 512'(l[511:480]), 512'd63);
    check_output("t2_first_wr_cyc", 512'(get_cyc(0)), 512'd18);
    check_output("t2_wr1_cyc", 512'(get_cyc(1)), 512'd36);
    check_output("t2_wr2_cyc", 512'(get_cyc(2)), 512'd54);
    check_output("t2_wr3_cyc", 512'(get_cyc(3)), 512'd72);
    check_output("t2_done_cyc", 512'(done_cyc - start_cyc), 512'd79);

    // 40-cycle back-pressure while line 1 waits in SEND
    load_mem(1);
    clear_log();
    apply_start(42'h2000);
    wait_until(30);
    bus.wr_alm_full = 1'b1;
    repeat (40) @(negedge clk);
    bus.wr_alm_full = 1'b0;
    wait_done("t3", 300);
    check_drain("t3", 1, 42'h2000);
    check_output("t3_wr0_cyc", 512'(get_cyc(0)), 512'd18);
    check_output("t3_wr1_cyc", 512'(get_cyc(1)), 512'd71);
    check_output("t3_wr2_cyc", 512'(get_cyc(2)), 512'd89);
    check_output("t3_done_cyc", 512'(done_cyc - start_cyc), 512'd114);

    // Line address wraps modulo 2^42
    load_mem(2);
    clear_log();
    apply_start(42'h3FF_FFFF_FFFE);
    wait_done("t4", 200);
    check_drain("t4", 2, 42'h3FF_FFFF_FFFE);
    check_output("t4_addr2_zero", 512'(get_addr(2)), 512'd0);

    // Reset during FILL of line 2 aborts; a fresh start then drains fully
    load_mem(0);
    clear_log();
    apply_start(42'h4000);
    wait_until(40);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("t5_busy_after_rst", 512'(bus.busy), 512'd0);
    repeat (60) @(negedge clk);
    check_output("t5_nwrites_aborted", 512'(wa_q.size()), 512'd2);
    check_output("t5_no_done", 512'(done_cnt), 512'd0);
    load_mem(1);
    clear_log();
    apply_start(42'h5000);
    wait_done("t5b", 200);
    check_drain("t5b", 1, 42'h5000);

    // Stray responses while idle, start while busy, start during FIN
    load_mem(0);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_manual = 1'b1;
      @(negedge clk);
      rsp_manual = 1'b0;
    end
    check_output("t6_idle_busy", 512'(bus.busy), 512'd0);
    apply_start(42'h6000);
    wait_until(5);
    pulse_start_raw(42'h7777);
    wait_until(75);
    pulse_start_raw(42'h7778);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.done) begin
          seen = 1'b1;
          break;
        end
      end
      check_output("t6_done_seen", 512'(seen), 512'd1);
    end
    bus.base_addr = 42'h8000;
    bus.start = 1'b1;
    @(negedge clk);
    check_output("t6_fin_start_ignored", 512'(bus.busy), 512'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check_output("t6_idle_start_taken", 512'(bus.busy), 512'd1);
    check_drain("t6", 0, 42'h6000);
    clear_log();
    start_cyc = cyc;
    wait_done("t6b", 200);
    check_drain("t6b", 0, 42'h8000);
    check_output("t6b_first_wr_cyc", 512'(get_cyc(0)), 512'd18);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
